// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, payload type and helpers for the CDB arbiter slice.
package cdb_arbiter_pkg;
  localparam int unsigned NUM_FU         = 4;
  localparam int unsigned NUM_LSN        = 4;
  localparam int unsigned ROB_ENTRY      = 4;
  localparam int unsigned ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY);
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned FU_IDX_W       = $clog2(NUM_FU);

  localparam int unsigned FU_ALU = 0;
  localparam int unsigned FU_LSU = 1;
  localparam int unsigned FU_BPU = 2;
  localparam int unsigned FU_CSR = 3;

  localparam int unsigned LSN_RS1_FETCH = 0;
  localparam int unsigned LSN_RS2_FETCH = 1;
  localparam int unsigned LSN_RS1_ISSUE = 2;
  localparam int unsigned LSN_RS2_ISSUE = 3;

  typedef logic [ROB_ENTRY_LOG2-1:0] rob_tag_t;

  typedef struct packed {
    rob_tag_t                tag;
    logic [DATA_WIDTH-1:0]   data;
  } cdb_pkt_t;

  // Index of the set bit in a one-hot FU vector (0 when empty).
  function automatic logic [FU_IDX_W-1:0] onehot_idx(input logic [NUM_FU-1:0] oh);
    onehot_idx = '0;
    for (int unsigned i = 0; i < NUM_FU; i++)
      if (oh[i]) onehot_idx = onehot_idx | FU_IDX_W'(i);
  endfunction

  // True when no two requesting FUs present the same ROB tag.
  function automatic logic tags_distinct(input logic [NUM_FU-1:0]                req,
                                         input logic [NUM_FU*ROB_ENTRY_LOG2-1:0] tags);
    tags_distinct = 1'b1;
    for (int unsigned i = 0; i < NUM_FU; i++)
      for (int unsigned j = i + 1; j < NUM_FU; j++)
        if (req[i] && req[j] &&
            tags[i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2] == tags[j*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2])
          tags_distinct = 1'b0;
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// FU write-back, broadcast and listener signals of the Common Data Bus.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_FU-1:0]                fu_req;
  logic [NUM_FU*ROB_ENTRY_LOG2-1:0] fu_tag;
  logic [NUM_FU*DATA_WIDTH-1:0]     fu_data;
  logic [NUM_FU-1:0]                fu_gnt;
  logic                             cdb_valid;
  rob_tag_t                         cdb_tag;
  logic [DATA_WIDTH-1:0]            cdb_data;
  logic [NUM_LSN-1:0]               lsn_request;
  logic [NUM_LSN*ROB_ENTRY_LOG2-1:0] lsn_id;
  logic [NUM_LSN-1:0]               lsn_hit;
  logic [NUM_LSN*DATA_WIDTH-1:0]    lsn_data;

  modport master (
    output fu_req, fu_tag, fu_data, lsn_request, lsn_id,
    input  fu_gnt, cdb_valid, cdb_tag, cdb_data, lsn_hit, lsn_data
  );

  modport slave (
    input  fu_req, fu_tag, fu_data, lsn_request, lsn_id,
    output fu_gnt, cdb_valid, cdb_tag, cdb_data, lsn_hit, lsn_data
  );
endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins a one-hot grant.
module cdb_arbiter_rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);
  logic [PTR_W:0] pos;
  logic           found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(N)) pos = pos - (PTR_W+1)'(N);
      if (!found && req[pos[PTR_W-1:0]]) begin
        gnt[pos[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus owner: round-robin FU grant, 1-cycle registered broadcast, listener tag match.
// Optional CDB_FLUSH_EN adds cdb_flush, which kills the grant and rewinds the pointer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic CLK,
  input  logic RSTN,
`ifdef CDB_FLUSH_EN
  input  logic cdb_flush,
`endif
  cdb_arbiter_if.slave bus
);
  logic [FU_IDX_W-1:0] rr_ptr;
  logic [FU_IDX_W-1:0] gnt_idx;
  logic [FU_IDX_W-1:0] ptr_nxt;
  logic [NUM_FU-1:0]   arb_req;
  logic [NUM_FU-1:0]   gnt;
  logic                xfer;
  logic                flush_c;
  logic                valid_q;
  cdb_pkt_t            cdb_q;
  cdb_pkt_t            sel;
  logic [NUM_LSN-1:0]  lsn_hit_c;

`ifdef CDB_FLUSH_EN
  assign flush_c = cdb_flush;
`else
  assign flush_c = 1'b0;
`endif

  assign arb_req = flush_c ? '0 : bus.fu_req;

  cdb_arbiter_rr_arbiter #(.N(NUM_FU)) u_rr (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign xfer    = |gnt;
  assign gnt_idx = onehot_idx(gnt);
  assign ptr_nxt = (gnt_idx == FU_IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + FU_IDX_W'(1);

  // Payload mux of the granted FU.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) begin
        sel.tag  = bus.fu_tag[i*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
        sel.data = bus.fu_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Broadcast register and round-robin pointer; tag/data hold across idle cycles.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= 1'b0;
      cdb_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      valid_q <= xfer;
      if (xfer) cdb_q <= sel;
      if (flush_c)   rr_ptr <= '0;
      else if (xfer) rr_ptr <= ptr_nxt;
    end
  end

  // Listeners only ever see the registered broadcast, never the in-flight grant.
  always_comb begin
    lsn_hit_c = '0;
    for (int unsigned k = 0; k < NUM_LSN; k++)
      lsn_hit_c[k] = bus.lsn_request[k] & valid_q &
                     (bus.lsn_id[k*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2] == cdb_q.tag);
  end

  assign bus.fu_gnt    = gnt;
  assign bus.cdb_valid = valid_q;
  assign bus.cdb_tag   = cdb_q.tag;
  assign bus.cdb_data  = cdb_q.data;
  assign bus.lsn_hit   = lsn_hit_c;
  assign bus.lsn_data  = {NUM_LSN{cdb_q.data}};

  a_tags_distinct: assert property (@(posedge CLK) disable iff (!RSTN)
                                    tags_distinct(bus.fu_req, bus.fu_tag));
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: spec-level model checked every cycle plus directed literal checks.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic CLK   = 1'b0;
  logic RSTN  = 1'b0;
  logic flush_v = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
`ifdef CDB_FLUSH_EN
    .cdb_flush (flush_v),
`endif
    .bus       (bus)
  );

  always #5 CLK = ~CLK;

  // Model state: expected pointer and broadcast.
  int          m_ptr;
  int          m_win;
  logic        m_valid;
  logic [1:0]  m_tag;
  logic [31:0] m_data;

  function automatic int winner(input logic [3:0] req, input int ptr, input logic fl);
    if (fl) return -1;
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  always_comb m_win = winner(bus.fu_req, m_ptr, flush_v);

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_ptr   <= 0;
      m_valid <= 1'b0;
      m_tag   <= '0;
      m_data  <= '0;
    end else if (m_win >= 0) begin
      m_valid <= 1'b1;
      m_tag   <= bus.fu_tag[m_win*2 +: 2];
      m_data  <= bus.fu_data[m_win*32 +: 32];
      m_ptr   <= (m_win + 1) % 4;
    end else begin
      m_valid <= 1'b0;
      if (flush_v) m_ptr <= 0;
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge CLK) begin
    logic [3:0] eg;
    logic [3:0] eh;
    eg = (m_win >= 0) ? 4'(1 << m_win) : 4'b0;
    eh = '0;
    for (int k = 0; k < 4; k++)
      eh[k] = bus.lsn_request[k] && m_valid && (bus.lsn_id[k*2 +: 2] == m_tag);
    chk("model_gnt",      128'(bus.fu_gnt),    128'(eg));
    chk("model_valid",    128'(bus.cdb_valid), 128'(m_valid));
    chk("model_tag",      128'(bus.cdb_tag),   128'(m_tag));
    chk("model_data",     128'(bus.cdb_data),  128'(m_data));
    chk("model_lsn_hit",  128'(bus.lsn_hit),   128'(eh));
    chk("model_lsn_data", bus.lsn_data,        {4{m_data}});
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_fu(input int i, input logic r, input logic [1:0] t, input logic [31:0] d);
    bus.fu_req[i]         = r;
    bus.fu_tag[i*2 +: 2]  = t;
    bus.fu_data[i*32 +: 32] = d;
  endtask

  task automatic drop_all();
    for (int i = 0; i < 4; i++) set_fu(i, 1'b0, 2'(i), 32'h0);
  endtask

  initial begin
    int w;
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;

    bus.fu_req = '0; bus.fu_tag = '0; bus.fu_data = '0;
    bus.lsn_request = 4'b1111; bus.lsn_id = '0;

    // Reset state: a tag-0 listener must not hit while nothing is valid.
    repeat (2) @(negedge CLK);
    chk("rst_valid",   128'(bus.cdb_valid), 128'(0));
    chk("rst_tag",     128'(bus.cdb_tag),   128'(0));
    chk("rst_data",    128'(bus.cdb_data),  128'(0));
    chk("rst_lsn_hit", 128'(bus.lsn_hit),   128'(0));
    chk("rst_gnt",     128'(bus.fu_gnt),    128'(0));
    step(); RSTN = 1'b1;

    // Single ALU result.
    set_fu(FU_ALU, 1'b1, 2'd2, 32'hDEAD_BEEF);
    @(negedge CLK); chk("c1_gnt", 128'(bus.fu_gnt), 128'(4'b0001));
    step(); set_fu(FU_ALU, 1'b1, 2'd0, 32'hA0); set_fu(FU_LSU, 1'b1, 2'd1, 32'hA1);
    @(negedge CLK);
    chk("c1_valid", 128'(bus.cdb_valid), 128'(1));
    chk("c1_tag",   128'(bus.cdb_tag),   128'(2));
    chk("c1_data",  128'(bus.cdb_data),  128'(32'hDEAD_BEEF));
    chk("c2_gnt_ptr1", 128'(bus.fu_gnt), 128'(4'b0010));
    step(); set_fu(FU_LSU, 1'b0, 2'd1, 32'h0);
    @(negedge CLK); chk("c3_gnt_wrap_search", 128'(bus.fu_gnt), 128'(4'b0001));
    step(); set_fu(FU_ALU, 1'b0, 2'd0, 32'h0); set_fu(FU_CSR, 1'b1, 2'd3, 32'hA3);
    @(negedge CLK); chk("c4_gnt_csr", 128'(bus.fu_gnt), 128'(4'b1000));

    // All four requesting from pointer 0.
    step();
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 2'(i), 32'hB0 + 32'(i));
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); chk("rr_all_gnt", 128'(bus.fu_gnt), 128'(exp_seq[c]));
      if (c > 0) chk("rr_all_tag", 128'(bus.cdb_tag), 128'(c - 1));
      step();
    end
    drop_all();
    @(negedge CLK); chk("rr_all_last_data", 128'(bus.cdb_data), 128'(32'hB3));
    step(); for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 2'(i), 32'hC0 + 32'(i));
    @(negedge CLK); chk("rr_ptr_wrapped", 128'(bus.fu_gnt), 128'(4'b0001));
    step(); drop_all(); set_fu(FU_BPU, 1'b1, 2'd2, 32'hC2);
    @(negedge CLK); chk("bpu_gnt", 128'(bus.fu_gnt), 128'(4'b0100));
    step(); drop_all(); set_fu(FU_ALU, 1'b1, 2'd0, 32'hD0); set_fu(FU_CSR, 1'b1, 2'd3, 32'hD3);
    @(negedge CLK); chk("ptr3_gnt_csr", 128'(bus.fu_gnt), 128'(4'b1000));
    step(); set_fu(FU_CSR, 1'b0, 2'd3, 32'h0);
    @(negedge CLK); chk("ptr0_gnt_alu", 128'(bus.fu_gnt), 128'(4'b0001));

    // Listener match on tag 1.
    step(); drop_all(); set_fu(FU_LSU, 1'b1, 2'd1, 32'h1234_5678);
    bus.lsn_request = 4'b1101; bus.lsn_id = {2'd1, 2'd1, 2'd3, 2'd1};
    step(); drop_all();
    @(negedge CLK);
    chk("lsn_hit",  128'(bus.lsn_hit), 128'(4'b1101));
    chk("lsn_data", bus.lsn_data, {4{32'h1234_5678}});
    step();
    @(negedge CLK);
    chk("idle_valid",   128'(bus.cdb_valid), 128'(0));
    chk("idle_tag",     128'(bus.cdb_tag),   128'(1));
    chk("idle_data",    128'(bus.cdb_data),  128'(32'h1234_5678));
    chk("idle_lsn_hit", 128'(bus.lsn_hit),   128'(0));

    // Back-to-back grants to a lone requester with changing payload.
    for (int c = 0; c < 3; c++) begin
      step(); set_fu(FU_BPU, 1'b1, 2'd2, 32'hE0 + 32'(c));
      @(negedge CLK); chk("b2b_gnt", 128'(bus.fu_gnt), 128'(4'b0100));
    end
    step(); drop_all();

    // Random traffic obeying the hold rule; tag fixed per FU keeps tags distinct.
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK); w = m_win;
      step();
      for (int i = 0; i < 4; i++)
        if (!bus.fu_req[i] || i == w) set_fu(i, 1'($urandom_range(0, 1)), 2'(i), $urandom);
      bus.lsn_request = 4'($urandom);
      bus.lsn_id      = 8'($urandom);
    end
    step(); drop_all();

`ifdef CDB_FLUSH_EN
    step(); set_fu(FU_LSU, 1'b1, 2'd1, 32'hF1);
    step(); for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 2'(i), 32'hF0 + 32'(i)); flush_v = 1'b1;
    @(negedge CLK); chk("flush_gnt", 128'(bus.fu_gnt), 128'(0));
    step(); flush_v = 1'b0;
    @(negedge CLK);
    chk("flush_valid", 128'(bus.cdb_valid), 128'(0));
    chk("flush_ptr0",  128'(bus.fu_gnt),    128'(4'b0001));
    step(); drop_all();
`endif

    // Asynchronous reset in the middle of a broadcast.
    step(); set_fu(FU_LSU, 1'b1, 2'd1, 32'h5555_AAAA);
    step(); drop_all();
    chk("pre_rst_valid", 128'(bus.cdb_valid), 128'(1));
    #2 RSTN = 1'b0;
    #1;
    chk("async_rst_valid", 128'(bus.cdb_valid), 128'(0));
    chk("async_rst_tag",   128'(bus.cdb_tag),   128'(0));
    chk("async_rst_data",  128'(bus.cdb_data),  128'(0));
    repeat (2) @(negedge CLK);
    step(); RSTN = 1'b1;
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 2'(i), 32'h70 + 32'(i));
    @(negedge CLK); chk("post_rst_ptr0", 128'(bus.fu_gnt), 128'(4'b0001));
    step(); drop_all();
    step();
    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Owns the Common Data Bus (CDB) and shares it between the function units (ALU, LSU, BPU, CSR) that complete out of order.
- Each cycle, a round-robin arbiter grants at most one FU result and broadcasts it for one cycle as {rob tag, data}.
- Also serves the listener ports used by the instruction issuer (rs1/rs2 fetch and issue listeners): each listener gets a tag-match hit and the broadcast data.
- Sits between the FU write-back outputs and the issuer/ROB.

Parameters:
- NUM_FU, 4, number of requesting function units; index 0=ALU, 1=LSU, 2=BPU, 3=CSR.
- NUM_LSN, 4, number of listener ports; 0=rs1_fetch, 1=rs2_fetch, 2=rs1_issue, 3=rs2_issue.
- ROB_ENTRY, 4, ROB depth; ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY).
- DATA_WIDTH, 32, result width.

Ports:
- CLK  input  1  clock.
- RSTN  input  1  asynchronous, active-low reset.
- fu_req  input  NUM_FU  FU has a result; held with payload until granted.
- fu_tag  input  NUM_FU*ROB_ENTRY_LOG2  ROB entry of each FU result; slice i belongs to FU i.
- fu_data  input  NUM_FU*DATA_WIDTH  result data; slice i belongs to FU i.
- fu_gnt  output  NUM_FU  one-hot grant, combinational.
- cdb_valid  output  1  broadcast valid, registered.
- cdb_tag  output  ROB_ENTRY_LOG2  broadcast ROB tag, registered.
- cdb_data  output  DATA_WIDTH  broadcast data, registered.
- lsn_request  input  NUM_LSN  listener is waiting on a tag.
- lsn_id  input  NUM_LSN*ROB_ENTRY_LOG2  tag each listener waits on.
- lsn_hit  output  NUM_LSN  listener tag matches the current broadcast.
- lsn_data  output  NUM_LSN*DATA_WIDTH  broadcast data per listener.
- cdb_flush  input  1  present only with CDB_FLUSH_EN.

Behaviour:
- Reset (RSTN low, async): cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0.
  - lsn_hit therefore reads 0.
  - fu_gnt=0 while fu_req=0; FUs keep fu_req low during reset.
- Arbitration is combinational in cycle T.
  - Search starts at rr_ptr and wraps modulo NUM_FU; the first i with fu_req[i]=1 gets fu_gnt[i]=1.
  - At most one grant per cycle; no grant if fu_req is all zero.
- Handshake: a transfer occurs when fu_req[i] & fu_gnt[i].
  - The FU may drop or replace its payload on the next cycle.
  - An ungranted FU must hold req, tag and data stable.
- Pointer update: on a transfer from FU i, rr_ptr <= (i+1) mod NUM_FU, including wrap from NUM_FU-1 to 0. With no transfer, rr_ptr holds.
- Broadcast latency is 1 cycle. The transfer in cycle T gives cdb_valid=1, cdb_tag=fu_tag[i], cdb_data=fu_data[i] in cycle T+1.
  - With no transfer in T, cdb_valid=0 in T+1 and cdb_tag/cdb_data hold their last value.
- Throughput: one broadcast per cycle; back-to-back grants are allowed, to the same FU if it is the only requester. The CDB has no backpressure.
- Listeners are combinational on the registered broadcast:
  - lsn_hit[k] = lsn_request[k] & cdb_valid & (lsn_id[k]==cdb_tag).
  - lsn_data[k] = cdb_data, unconditionally.
- Several listeners may hit on the same broadcast; each is independent.
- A request and a broadcast in the same cycle do not interact: the listener sees only the registered broadcast, never the in-flight grant.
- Duplicate tags from two FUs are illegal. Cover with an assertion that tags of simultaneously requesting FUs are distinct.
- Reset mid-operation: the broadcast is dropped; ungranted FUs re-request after reset.

Optional Feature:
- Macro: CDB_FLUSH_EN.
- With the macro, the cdb_flush port exists. When cdb_flush=1 in cycle T:
  - fu_gnt is forced to 0.
  - cdb_valid=0 in T+1.
  - rr_ptr <= 0.
  - FUs are expected to drop their requests.
- Without the macro, the port is absent and there is no flush path.

Decomposition:
- Shared package: FU index constants (FU_ALU=0, FU_LSU=1, FU_BPU=2, FU_CSR=3), listener index constants, ROB_ENTRY_LOG2 derivation.
- One natural sub-module: rr_arbiter (parameter N; inputs req and ptr; output one-hot gnt).
- Listener compare logic and the broadcast register stay in the top level.

Test Plan:
- Reset, then fu_req=4'b0001 with tag=2, data=32'hDEAD_BEEF → fu_gnt=0001 the same cycle; next cycle cdb_valid=1, tag=2, data=DEADBEEF; rr_ptr=1.
- fu_req=4'b1111 held for 4 cycles, rr_ptr=0 → grants in order 0001, 0010, 0100, 1000; 4 consecutive broadcasts; rr_ptr wraps to 0.
- rr_ptr=3, fu_req=4'b1001 → grant 1000, then 0001.
- Broadcast tag=1 with lsn_request=4'b1101 and lsn_id={1,3,1,1} (listener k at slice k) → lsn_hit=4'b1101, all lsn_data=cdb_data; with cdb_valid=0 → lsn_hit=0.
- Idle cycle after a broadcast → cdb_valid=0, tag/data unchanged, lsn_hit=0.
- With CDB_FLUSH_EN: fu_req=1111 and cdb_flush=1 → fu_gnt=0, next cycle cdb_valid=0, rr_ptr=0. Also assert RSTN mid-stream → outputs return to 0 asynchronously.
